// File: rtl/seven_seg_scanner_if.sv
// Bus between a display-value producer and the seven_seg_scanner.
// Value/DP updates flow in; the scanned digit code, anode enables and the update ack flow out.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value_bcd;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [3:0]                bcd_out;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic                      upd_ack;

  modport master (
    output load, value_bcd, dp_mask,
    input  bcd_out, dp_n, anode_n, upd_ack
  );

  modport slave (
    input  load, value_bcd, dp_mask,
    output bcd_out, dp_n, anode_n, upd_ack
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for a common-anode 7-segment display.
// A new value is shadowed in a pending register and only copied to the
// display register at the end of a frame (tick on the last digit), so a
// frame is never drawn with a mix of old and new digits.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  seven_seg_scanner_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   disp_dig;
  logic [NUM_DIGITS-1:0]        disp_dp;
  logic [NUM_DIGITS-1:0][3:0]   pend_dig;
  logic [NUM_DIGITS-1:0]        pend_dp;
  logic                         pend_vld;
  logic [NUM_DIGITS-1:0]        blank;

  logic tick, last, commit;

  assign tick   = (presc == PW'(REFRESH_DIV - 1));
  assign last   = (idx == IW'(NUM_DIGITS - 1));
  assign commit = tick && last && pend_vld;

`ifdef LEADING_ZERO_BLANK_EN
  logic keep;
  // Walk down from the top digit; once a non-zero digit or a lit DP is seen,
  // that digit and everything below it stays visible. Digit 0 always shows.
  always_comb begin
    keep  = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      keep     = keep | (disp_dig[i] != 4'd0) | disp_dp[i];
      blank[i] = ~keep;
    end
  end
`else
  assign blank = '0;
`endif

  // Prescaler, digit index, pending shadow register and frame commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      idx      <= '0;
      disp_dig <= '0;
      disp_dp  <= '0;
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (tick) begin
        presc <= '0;
        idx   <= last ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      // Commit takes the old pending contents; a same-cycle load refills
      // pending and keeps the flag set for the next frame.
      if (commit) begin
        disp_dig <= pend_dig;
        disp_dp  <= pend_dp;
      end
      if (bus.load) begin
        pend_dig <= bus.value_bcd;
        pend_dp  <= bus.dp_mask;
        pend_vld <= 1'b1;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Registered display outputs, one cycle behind the selecting state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bcd_out <= 4'b0000;
      bus.dp_n    <= 1'b1;
      bus.anode_n <= '1;
      bus.upd_ack <= 1'b0;
    end else begin
      bus.bcd_out <= disp_dig[idx];
      bus.dp_n    <= ~disp_dp[idx];
      bus.upd_ack <= commit;
      if (presc >= PW'(BLANK_CYCLES) && !blank[idx])
        bus.anode_n <= ~(NUM_DIGITS'(1) << idx);
      else
        bus.anode_n <= '1;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Frames are 32 cycles; run_frame checks every cycle of one
// frame against a hand-given display value, mask and blank pattern.
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  seven_seg_scanner_if #(.NUM_DIGITS(4)) bus();

  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] BL_ZERO = 4'b1110;
  localparam logic [3:0] BL_0042 = 4'b1100;
  localparam logic [3:0] BL_0005 = 4'b1000;
`else
  localparam logic [3:0] BL_ZERO = 4'b0000;
  localparam logic [3:0] BL_0042 = 4'b0000;
  localparam logic [3:0] BL_0005 = 4'b0000;
`endif

  // One frame starting at a frame boundary. Load offsets k (1..32) assert
  // load in the cycle ending at the frame's k-th edge; -1 disables.
  task automatic run_frame(input string nm,
                           input logic [15:0] dv, input logic [3:0] dm,
                           input logic [3:0] bl, input logic ack_end,
                           input int l1, input logic [15:0] v1, input logic [3:0] m1,
                           input int l2, input logic [15:0] v2, input logic [3:0] m2);
    for (int k = 1; k <= 32; k++) begin
      int p, d;
      logic [3:0] ea, eb;
      logic ed, ek;
      if (k == l1) begin bus.load = 1'b1; bus.value_bcd = v1; bus.dp_mask = m1; end
      if (k == l2) begin bus.load = 1'b1; bus.value_bcd = v2; bus.dp_mask = m2; end
      @(posedge clk); #1;
      bus.load = 1'b0;
      p  = (k - 1) % 8;
      d  = (k - 1) / 8;
      ea = (p >= 2 && !bl[d]) ? ~(4'b0001 << d) : 4'b1111;
      eb = dv[4*d +: 4];
      ed = ~dm[d];
      ek = (k == 32) ? ack_end : 1'b0;
      vectors += 4;
      if (bus.anode_n !== ea) begin
        miscompares++;
        $display("FAIL %s anode_n k=%0d got %b want %b", nm, k, bus.anode_n, ea);
      end
      if (bus.bcd_out !== eb) begin
        miscompares++;
        $display("FAIL %s bcd_out k=%0d got %h want %h", nm, k, bus.bcd_out, eb);
      end
      if (bus.dp_n !== ed) begin
        miscompares++;
        $display("FAIL %s dp_n k=%0d got %b want %b", nm, k, bus.dp_n, ed);
      end
      if (bus.upd_ack !== ek) begin
        miscompares++;
        $display("FAIL %s upd_ack k=%0d got %b want %b", nm, k, bus.upd_ack, ek);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    vectors += 4;
    if (bus.anode_n !== 4'b1111) begin miscompares++; $display("FAIL %s anode_n got %b want 1111", nm, bus.anode_n); end
    if (bus.bcd_out !== 4'h0)    begin miscompares++; $display("FAIL %s bcd_out got %h want 0", nm, bus.bcd_out); end
    if (bus.dp_n !== 1'b1)       begin miscompares++; $display("FAIL %s dp_n got %b want 1", nm, bus.dp_n); end
    if (bus.upd_ack !== 1'b0)    begin miscompares++; $display("FAIL %s upd_ack got %b want 0", nm, bus.upd_ack); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle();
    run_frame("idle0", 16'h0000, 4'h0, BL_ZERO, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("idle1", 16'h0000, 4'h0, BL_ZERO, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_load();
    run_frame("load_wait", 16'h0000, 4'h0, BL_ZERO, 1'b1, 1, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
    run_frame("load_show", 16'h1234, 4'b0100, 4'b0000, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_load", 16'h1234, 4'b0100, 4'b0000, 1'b1, 3, 16'h1111, 4'h0, 10, 16'h2222, 4'h0);
    run_frame("b2b_show", 16'h2222, 4'h0, 4'b0000, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_load_at_commit();
    run_frame("lac_load",  16'h2222, 4'h0, 4'b0000, 1'b1, 5, 16'h9999, 4'h0, 32, 16'h5678, 4'h0);
    run_frame("lac_9999",  16'h9999, 4'h0, 4'b0000, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("lac_5678",  16'h5678, 4'h0, 4'b0000, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_non_bcd();
    run_frame("nbcd_load", 16'h5678, 4'h0, 4'b0000, 1'b1, 7, 16'hFA0B, 4'b1001, -1, 16'h0, 4'h0);
    run_frame("nbcd_show", 16'hFA0B, 4'b1001, 4'b0000, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    bus.load = 1'b1; bus.value_bcd = 16'h7777; bus.dp_mask = 4'hF;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    vectors++;
    if (bus.anode_n !== 4'b1011) begin
      miscompares++;
      $display("FAIL rst_mid pre anode_n got %b want 1011", bus.anode_n);
    end
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame("rst_mid_after", 16'h0000, 4'h0, BL_ZERO, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_leading_zero();
    run_frame("lz_0042_ld", 16'h0000, 4'h0, BL_ZERO, 1'b1, 1, 16'h0042, 4'h0, -1, 16'h0, 4'h0);
    run_frame("lz_0042",    16'h0042, 4'h0, BL_0042, 1'b1, 1, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
    run_frame("lz_0000",    16'h0000, 4'h0, BL_ZERO, 1'b1, 1, 16'h0005, 4'b0100, -1, 16'h0, 4'h0);
    run_frame("lz_0005",    16'h0005, 4'b0100, BL_0005, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.value_bcd = '0;
    bus.dp_mask = '0;
    test_reset();
    test_scan_idle();
    test_load();
    test_back_to_back();
    test_load_at_commit();
    test_non_bcd();
    test_reset_mid();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
